// File: rtl/gravsim_regfile_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : gravsim_regfile_arbiter_if
// Description : Host bus into the planet-state register file. The host
//               holds a request until a one-cycle ack comes back.
// Revision    : 1.0 - initial release
// ============================================================================
interface gravsim_regfile_arbiter_if #(
  parameter int AW = 7
) ();
  logic          host_req;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [31:0]   host_wdata;
  logic [31:0]   host_rdata;
  logic          host_ack;

  modport master (
    output host_req, host_we, host_addr, host_wdata,
    input  host_rdata, host_ack
  );

  modport slave (
    input  host_req, host_we, host_addr, host_wdata,
    output host_rdata, host_ack
  );
endinterface
`default_nettype wire

// File: rtl/gravsim_regfile_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : gravsim_regfile_arbiter
// Description : Planet-state register file shared between the host bus and
//               the physics FSM's two 3-word banks (FSM has priority), plus
//               the START/DONE step sequencer that launches the FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module gravsim_regfile_arbiter #(
  parameter int DEPTH = 113,
  parameter int AW    = 7
) (
  input  wire logic                 CLK,
  input  wire logic                 RESET,
  gravsim_regfile_arbiter_if.slave  hbus,
  input  wire logic [1:0]           FSM_re,
  input  wire logic [1:0]           FSM_we,
  input  wire logic [AW-1:0]        ADDR1,
  input  wire logic [AW-1:0]        ADDR2,
  input  wire logic [AW-1:0]        ADDR3,
  input  wire logic [AW-1:0]        ADDR4,
  input  wire logic [AW-1:0]        ADDR5,
  input  wire logic [AW-1:0]        ADDR6,
  input  wire logic [31:0]          DATA1,
  input  wire logic [31:0]          DATA2,
  input  wire logic [31:0]          DATA3,
  input  wire logic [31:0]          DATA4,
  input  wire logic [31:0]          DATA5,
  input  wire logic [31:0]          DATA6,
  output logic [31:0]               DATA1in,
  output logic [31:0]               DATA2in,
  output logic [31:0]               DATA3in,
  output logic [31:0]               DATA4in,
  output logic [31:0]               DATA5in,
  output logic [31:0]               DATA6in,
  output logic                      FSM_START,
  input  wire logic                 FSM_DONE,
  output logic [31:0]               G,
  output logic [31:0]               PLANET_NUM,
  output logic                      busy
);

  localparam logic [AW-1:0] C_ADDR_START = AW'(2);
  localparam logic [AW-1:0] C_ADDR_DONE  = AW'(3);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_KICK   = 2'd1,
    S_RUN    = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  state_t        state_q;
  logic          fsm_start_q;
  logic          busy_q;

  logic [31:0]   mem_q [DEPTH];
  logic [31:0]   mem_d [DEPTH];
  logic [31:0]   rd_q  [6];
  logic [31:0]   rd_d  [6];
  logic [31:0]   host_rdata_q, host_rdata_d;
  logic          host_ack_q, host_ack_d;

  logic [AW-1:0] fsm_addr [6];
  logic [31:0]   fsm_data [6];
  logic          host_grant;
  logic          launch;

  function automatic logic in_range(input logic [AW-1:0] a);
    return 32'(a) < 32'(DEPTH);
  endfunction

  // Flatten the six FSM address/data ports so the banks can be looped over
  always_comb begin
    fsm_addr[0] = ADDR1; fsm_addr[1] = ADDR2; fsm_addr[2] = ADDR3;
    fsm_addr[3] = ADDR4; fsm_addr[4] = ADDR5; fsm_addr[5] = ADDR6;
    fsm_data[0] = DATA1; fsm_data[1] = DATA2; fsm_data[2] = DATA3;
    fsm_data[3] = DATA4; fsm_data[4] = DATA5; fsm_data[5] = DATA6;
  end

  // Host only gets the array when the FSM is completely quiet and not in its ack cycle
  assign host_grant = hbus.host_req & ~host_ack_q & ~(|FSM_re) & ~(|FSM_we);
  assign launch     = host_grant & hbus.host_we & (hbus.host_addr == C_ADDR_START)
                    & (state_q == S_IDLE) & (|hbus.host_wdata);

  // Next storage contents: FSM writes in index order (highest wins), host, then sequencer
  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < 6; i++) begin
      if (((i < 3) ? FSM_we[0] : FSM_we[1]) && in_range(fsm_addr[i]) &&
          (fsm_addr[i] != C_ADDR_START) && (fsm_addr[i] != C_ADDR_DONE)) begin
        mem_d[fsm_addr[i]] = fsm_data[i];
      end
    end
    if (host_grant && hbus.host_we && in_range(hbus.host_addr)) begin
      if (hbus.host_addr == C_ADDR_START) begin
        // START is only writable between steps; a launch also clears DONE
        if (state_q == S_IDLE) begin
          mem_d[C_ADDR_START] = hbus.host_wdata;
          if (launch) mem_d[C_ADDR_DONE] = 32'd0;
        end
      end else begin
        mem_d[hbus.host_addr] = hbus.host_wdata;
      end
    end
    // Step completion overrides any same-cycle host write to DONE
    if (state_q == S_FINISH) begin
      mem_d[C_ADDR_DONE]  = 32'd1;
      mem_d[C_ADDR_START] = 32'd0;
    end
  end

  // Next read-port values: enabled banks capture old storage, others hold
  always_comb begin
    rd_d = rd_q;
    for (int i = 0; i < 6; i++) begin
      if ((i < 3) ? FSM_re[0] : FSM_re[1]) begin
        rd_d[i] = in_range(fsm_addr[i]) ? mem_q[fsm_addr[i]] : 32'd0;
      end
    end
    host_rdata_d = host_rdata_q;
    if (host_grant && !hbus.host_we) begin
      host_rdata_d = in_range(hbus.host_addr) ? mem_q[hbus.host_addr] : 32'd0;
    end
    host_ack_d = host_grant;
  end

  // Storage and read-data registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      mem_q        <= '{default: 32'd0};
      rd_q         <= '{default: 32'd0};
      host_rdata_q <= 32'd0;
      host_ack_q   <= 1'b0;
    end else begin
      mem_q        <= mem_d;
      rd_q         <= rd_d;
      host_rdata_q <= host_rdata_d;
      host_ack_q   <= host_ack_d;
    end
  end

  // Step sequencer with registered launch pulse and busy flag
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      fsm_start_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          fsm_start_q <= 1'b0;
          if (launch) begin
            state_q     <= S_KICK;
            fsm_start_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        S_KICK: begin
          state_q     <= S_RUN;
          fsm_start_q <= 1'b0;
        end
        S_RUN: begin
          if (FSM_DONE) state_q <= S_FINISH;
        end
        S_FINISH: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q     <= S_IDLE;
          fsm_start_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign hbus.host_rdata = host_rdata_q;
  assign hbus.host_ack   = host_ack_q;
  assign DATA1in         = rd_q[0];
  assign DATA2in         = rd_q[1];
  assign DATA3in         = rd_q[2];
  assign DATA4in         = rd_q[3];
  assign DATA5in         = rd_q[4];
  assign DATA6in         = rd_q[5];
  assign FSM_START       = fsm_start_q;
  assign busy            = busy_q;
  assign G               = mem_q[0];
  assign PLANET_NUM      = mem_q[1];

endmodule
`default_nettype wire

// File: tb/tb_gravsim_regfile_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_gravsim_regfile_arbiter
// Description : Directed self-checking bench for gravsim_regfile_arbiter.
//               Inputs change and outputs are sampled on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gravsim_regfile_arbiter;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [1:0]  FSM_re = '0, FSM_we = '0;
  logic [6:0]  ADDR1 = '0, ADDR2 = '0, ADDR3 = '0, ADDR4 = '0, ADDR5 = '0, ADDR6 = '0;
  logic [31:0] DATA1 = '0, DATA2 = '0, DATA3 = '0, DATA4 = '0, DATA5 = '0, DATA6 = '0;
  logic [31:0] DATA1in, DATA2in, DATA3in, DATA4in, DATA5in, DATA6in;
  logic        FSM_START;
  logic        FSM_DONE = 1'b0;
  logic [31:0] G, PLANET_NUM;
  logic        busy;

  int n_pass  = 0;
  int n_total = 0;

  gravsim_regfile_arbiter_if #(.AW(7)) hif ();

  gravsim_regfile_arbiter #(.DEPTH(113), .AW(7)) dut (
    .CLK(CLK), .RESET(RESET), .hbus(hif),
    .FSM_re(FSM_re), .FSM_we(FSM_we),
    .ADDR1(ADDR1), .ADDR2(ADDR2), .ADDR3(ADDR3),
    .ADDR4(ADDR4), .ADDR5(ADDR5), .ADDR6(ADDR6),
    .DATA1(DATA1), .DATA2(DATA2), .DATA3(DATA3),
    .DATA4(DATA4), .DATA5(DATA5), .DATA6(DATA6),
    .DATA1in(DATA1in), .DATA2in(DATA2in), .DATA3in(DATA3in),
    .DATA4in(DATA4in), .DATA5in(DATA5in), .DATA6in(DATA6in),
    .FSM_START(FSM_START), .FSM_DONE(FSM_DONE),
    .G(G), .PLANET_NUM(PLANET_NUM), .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One host transfer from a falling edge; returns read data, latency and any FSM_START seen
  task automatic host_op(input logic we, input logic [6:0] addr, input logic [31:0] wd,
                         output logic [31:0] rd, output int lat, output logic start_seen);
    hif.host_req   = 1'b1;
    hif.host_we    = we;
    hif.host_addr  = addr;
    hif.host_wdata = wd;
    lat = 0;
    start_seen = 1'b0;
    do begin
      @(negedge CLK);
      lat++;
      start_seen = start_seen | FSM_START;
    end while (!hif.host_ack && lat < 50);
    if (!hif.host_ack) chk("host_timeout", {31'd0, hif.host_ack}, 32'd1);
    rd = hif.host_rdata;
    hif.host_req = 1'b0;
    @(negedge CLK);
    start_seen = start_seen | FSM_START;
  endtask

  initial begin
    logic [31:0] rd;
    int          lat;
    logic        st;
    int          acks;

    hif.host_req = 1'b0; hif.host_we = 1'b0; hif.host_addr = '0; hif.host_wdata = '0;

    // Reset state
    repeat (2) @(negedge CLK);
    chk("rst_ack",   {31'd0, hif.host_ack}, 32'd0);
    chk("rst_rdata", hif.host_rdata, 32'd0);
    chk("rst_start", {31'd0, FSM_START}, 32'd0);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_G",     G, 32'd0);
    chk("rst_d1in",  DATA1in, 32'd0);
    RESET = 1'b0;
    @(negedge CLK);

    // Host write/read of G with single-cycle latency
    host_op(1'b1, 7'd0, 32'h4120_0000, rd, lat, st);
    chk("wr_lat", 32'(lat), 32'd1);
    chk("G_live", G, 32'h4120_0000);
    host_op(1'b0, 7'd0, 32'd0, rd, lat, st);
    chk("rd_lat", 32'(lat), 32'd1);
    chk("rd_G", rd, 32'h4120_0000);
    host_op(1'b1, 7'd1, 32'd3, rd, lat, st);
    chk("num_live", PLANET_NUM, 32'd3);

    // FSM writes both banks, then reads them back
    ADDR1 = 7'd4; ADDR2 = 7'd5; ADDR3 = 7'd6; ADDR4 = 7'd7; ADDR5 = 7'd8; ADDR6 = 7'd9;
    DATA1 = 32'd1; DATA2 = 32'd2; DATA3 = 32'd3; DATA4 = 32'd4; DATA5 = 32'd5; DATA6 = 32'd6;
    FSM_we = 2'b11;
    @(negedge CLK);
    FSM_we = 2'b00; FSM_re = 2'b11;
    @(negedge CLK);
    FSM_re = 2'b00;
    chk("fsm_rd1", DATA1in, 32'd1);
    chk("fsm_rd2", DATA2in, 32'd2);
    chk("fsm_rd3", DATA3in, 32'd3);
    chk("fsm_rd4", DATA4in, 32'd4);
    chk("fsm_rd5", DATA5in, 32'd5);
    chk("fsm_rd6", DATA6in, 32'd6);

    // Collision on word 10: ADDR5 beats ADDR2
    ADDR1 = 7'd11; ADDR2 = 7'd10; ADDR3 = 7'd12; ADDR4 = 7'd13; ADDR5 = 7'd10; ADDR6 = 7'd14;
    DATA1 = 32'd7; DATA2 = 32'd8; DATA3 = 32'd9; DATA4 = 32'd10; DATA5 = 32'd11; DATA6 = 32'd12;
    FSM_we = 2'b11;
    @(negedge CLK);
    FSM_we = 2'b00; FSM_re = 2'b11;
    @(negedge CLK);
    FSM_re = 2'b00;
    chk("coll_d2in", DATA2in, 32'd11);
    chk("coll_d5in", DATA5in, 32'd11);

    // Bank A alone: bank B outputs hold; same-cycle write returns old data; word 2 write dropped
    ADDR1 = 7'd4; ADDR2 = 7'd5; ADDR3 = 7'd2;
    DATA1 = 32'h55; DATA3 = 32'h77;
    FSM_we = 2'b01; FSM_re = 2'b01;
    @(negedge CLK);
    FSM_we = 2'b00; FSM_re = 2'b00;
    chk("old_data",  DATA1in, 32'd1);
    chk("bank_hold", DATA4in, 32'd10);
    FSM_re = 2'b01;
    @(negedge CLK);
    FSM_re = 2'b00;
    chk("new_data", DATA1in, 32'h55);
    host_op(1'b0, 7'd2, 32'd0, rd, lat, st);
    chk("fsm_w2_drop", rd, 32'd0);

    // Host read stalled by continuous FSM reads
    hif.host_req = 1'b1; hif.host_we = 1'b0; hif.host_addr = 7'd4;
    FSM_re = 2'b01;
    acks = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      if (hif.host_ack) acks++;
    end
    FSM_re = 2'b00;
    chk("stall_noack", 32'(acks), 32'd0);
    @(negedge CLK);
    chk("stall_ack",   {31'd0, hif.host_ack}, 32'd1);
    chk("stall_rdata", hif.host_rdata, 32'h55);
    hif.host_req = 1'b0;
    @(negedge CLK);

    // Launch a step
    hif.host_req = 1'b1; hif.host_we = 1'b1; hif.host_addr = 7'd2; hif.host_wdata = 32'd1;
    @(negedge CLK);
    hif.host_req = 1'b0;
    chk("go_ack",   {31'd0, hif.host_ack}, 32'd1);
    chk("go_start", {31'd0, FSM_START}, 32'd1);
    chk("go_busy",  {31'd0, busy}, 32'd1);
    @(negedge CLK);
    chk("go_pulse1", {31'd0, FSM_START}, 32'd0);
    host_op(1'b0, 7'd3, 32'd0, rd, lat, st);
    chk("go_done0", rd, 32'd0);
    repeat (20) @(negedge CLK);
    chk("run_busy", {31'd0, busy}, 32'd1);
    FSM_DONE = 1'b1;
    @(negedge CLK);
    FSM_DONE = 1'b0;
    chk("fin_busy", {31'd0, busy}, 32'd1);
    @(negedge CLK);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    host_op(1'b0, 7'd3, 32'd0, rd, lat, st);
    chk("done_set", rd, 32'd1);
    host_op(1'b0, 7'd2, 32'd0, rd, lat, st);
    chk("start_clr", rd, 32'd0);

    // Second step: START write during RUN ignored; FINISH beats same-cycle DONE write
    host_op(1'b1, 7'd2, 32'd1, rd, lat, st);
    chk("go2_busy", {31'd0, busy}, 32'd1);
    host_op(1'b0, 7'd3, 32'd0, rd, lat, st);
    chk("go2_done0", rd, 32'd0);
    host_op(1'b1, 7'd2, 32'd5, rd, lat, st);
    chk("run_w2_ack", 32'(lat), 32'd1);
    chk("run_w2_nostart", {31'd0, st}, 32'd0);
    host_op(1'b0, 7'd2, 32'd0, rd, lat, st);
    chk("run_w2_kept", rd, 32'd1);
    FSM_DONE = 1'b1;
    @(negedge CLK);
    FSM_DONE = 1'b0;
    hif.host_req = 1'b1; hif.host_we = 1'b1; hif.host_addr = 7'd3; hif.host_wdata = 32'd0;
    @(negedge CLK);
    hif.host_req = 1'b0;
    chk("fin_w3_ack", {31'd0, hif.host_ack}, 32'd1);
    @(negedge CLK);
    host_op(1'b0, 7'd3, 32'd0, rd, lat, st);
    chk("fin_wins", rd, 32'd1);
    host_op(1'b1, 7'd3, 32'd0, rd, lat, st);
    host_op(1'b0, 7'd3, 32'd0, rd, lat, st);
    chk("host_clr_done", rd, 32'd0);

    // Third step, reset during RUN
    host_op(1'b1, 7'd2, 32'd1, rd, lat, st);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    chk("mid_rst_busy",  {31'd0, busy}, 32'd0);
    chk("mid_rst_start", {31'd0, FSM_START}, 32'd0);
    chk("mid_rst_G",     G, 32'd0);
    chk("mid_rst_num",   PLANET_NUM, 32'd0);
    FSM_DONE = 1'b1;
    @(negedge CLK);
    FSM_DONE = 1'b0;
    @(negedge CLK);
    chk("late_done_busy", {31'd0, busy}, 32'd0);
    host_op(1'b0, 7'd3, 32'd0, rd, lat, st);
    chk("late_done_w3", rd, 32'd0);
    host_op(1'b0, 7'd4, 32'd0, rd, lat, st);
    chk("rst_word4", rd, 32'd0);

    // Out-of-range address
    host_op(1'b1, 7'd5, 32'h0000_dead, rd, lat, st);
    host_op(1'b0, 7'd5, 32'd0, rd, lat, st);
    chk("w5", rd, 32'h0000_dead);
    host_op(1'b1, 7'd120, 32'h1234_5678, rd, lat, st);
    host_op(1'b0, 7'd120, 32'd0, rd, lat, st);
    chk("oor_rd", rd, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
